// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle RV32I subset core with loadable instruction memory, halt/illegal detection and retire counter
module multicycle_core #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 16,
  parameter int RESULT_REG = 3,
  localparam int AW        = $clog2(IMEM_DEPTH)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IMEM_WE,
  input  logic [AW-1:0]   IMEM_WADDR,
  input  logic [31:0]     IMEM_WDATA,
  input  logic            START,
  output logic            BUSY,
  output logic            HALTED,
  output logic            ILLEGAL,
  output logic [31:0]     PC_OUT,
  output logic [31:0]     RETIRED,
  output logic [XLEN-1:0] RESULT
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, WRITE, HALT} state_t;
  localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1);
  state_t          state_q;
  logic [31:0]     pc_q, retired_q, inst_q;
  logic            illegal_q;
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic [XLEN-1:0] regs_q [32];
  logic [31:0]     imem_q [IMEM_DEPTH];
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] imm_i, alu_d;
  logic [31:0]     imm_b, target_d, next_pc_d;
  logic            is_r, is_i, is_b, taken_d, bad_d, ecall_d, wr_d;
  assign {f7, rs2, rs1, f3, rd, opc} = inst_q;
  assign BUSY    = state_q inside {FETCH, DECODE, EXECUTE, WRITE};
  assign HALTED  = state_q == HALT;
  assign ILLEGAL = illegal_q;
  assign PC_OUT  = pc_q;
  assign RETIRED = retired_q;
  assign RESULT  = regs_q[RESULT_REG];
  always_comb begin
    imm_i     = {{(XLEN-12){inst_q[31]}}, inst_q[31:20]};
    imm_b     = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
    is_r      = opc == 7'b0110011 && ((f7 == 7'b0000000 && f3 != 3'b011) || (f7 == 7'b0100000 && f3 == 3'b000));
    is_i      = opc == 7'b0010011 && f3 == 3'b000;
    is_b      = opc == 7'b1100011 && f3[2:1] == 2'b00;
    taken_d   = is_b && ((rs1_q == rs2_q) ^ f3[0]);
    target_d  = taken_d ? pc_q + imm_b : pc_q + 32'd4;
    next_pc_d = target_d & PC_MASK;
    ecall_d   = inst_q == 32'h0000_0073;
    bad_d     = !(is_r || is_i || is_b) || target_d[1:0] != 2'b00;
    wr_d      = (is_r || is_i) && rd != 5'd0;
    alu_d     = rs1_q + imm_i;
    if (is_r)
      case (f3)
        3'b000:  alu_d = f7[5] ? rs1_q - rs2_q : rs1_q + rs2_q;
        3'b001:  alu_d = rs1_q << rs2_q[4:0];
        3'b010:  alu_d = {{(XLEN-1){1'b0}}, $signed(rs1_q) < $signed(rs2_q)};
        3'b100:  alu_d = rs1_q ^ rs2_q;
        3'b101:  alu_d = rs1_q >> rs2_q[4:0];
        3'b110:  alu_d = rs1_q | rs2_q;
        default: alu_d = rs1_q & rs2_q;
      endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else
      case (state_q)
        IDLE, HALT:
          if (START) begin
            state_q   <= FETCH;
            pc_q      <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
          end
        FETCH: begin
          inst_q  <= imem_q[pc_q[AW+1:2]];
          state_q <= DECODE;
        end
        DECODE: begin
          rs1_q   <= rs1 == 5'd0 ? '0 : regs_q[rs1];
          rs2_q   <= rs2 == 5'd0 ? '0 : regs_q[rs2];
          state_q <= EXECUTE;
        end
        EXECUTE: begin
          state_q <= ecall_d || bad_d ? HALT : WRITE;
          if (bad_d && !ecall_d) illegal_q <= 1'b1;
        end
        WRITE: begin
          if (wr_d) regs_q[rd] <= alu_d;
          pc_q      <= next_pc_d;
          retired_q <= retired_q + 32'd1;
          state_q   <= FETCH;
        end
        default: state_q <= IDLE;
      endcase
  end
  always_ff @(posedge CLK)
    if (!RST && IMEM_WE && !BUSY) imem_q[IMEM_WADDR] <= IMEM_WDATA;
endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: scoreboard bench comparing halt-time state of multicycle_core against hand-computed results
module tb_multicycle_core;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  logic        clk = 1'b0, rst = 1'b1, we = 1'b0, start = 1'b0;
  logic [3:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        busy, halted, illegal;
  logic [31:0] pc, retired, result;
  logic        busy4, halted4, illegal4;
  logic [31:0] pc4, retired4, result4;
  logic        we_w = 1'b0, start_w = 1'b0;
  logic [1:0]  waddr_w = '0;
  logic [31:0] wdata_w = '0;
  logic        busy_w, halted_w, illegal_w;
  logic [31:0] pc_w, retired_w, result_w;
  int errors = 0, checks = 0, cyc = 0, fetch_cyc = 0, run = 0;
  logic h_prev = 1'b0, b_prev = 1'b0;
  typedef struct {logic [31:0] res, r4, ret, pc; logic ill; int dur;} exp_t;
  exp_t sb[$];
  logic [31:0] ops [10];
  logic [31:0] opx [10];
  multicycle_core dut (.CLK(clk), .RST(rst), .IMEM_WE(we), .IMEM_WADDR(waddr), .IMEM_WDATA(wdata),
    .START(start), .BUSY(busy), .HALTED(halted), .ILLEGAL(illegal), .PC_OUT(pc), .RETIRED(retired), .RESULT(result));
  multicycle_core #(.RESULT_REG(4)) dut4 (.CLK(clk), .RST(rst), .IMEM_WE(we), .IMEM_WADDR(waddr), .IMEM_WDATA(wdata),
    .START(start), .BUSY(busy4), .HALTED(halted4), .ILLEGAL(illegal4), .PC_OUT(pc4), .RETIRED(retired4), .RESULT(result4));
  multicycle_core #(.IMEM_DEPTH(4)) dutw (.CLK(clk), .RST(rst), .IMEM_WE(we_w), .IMEM_WADDR(waddr_w), .IMEM_WDATA(wdata_w),
    .START(start_w), .BUSY(busy_w), .HALTED(halted_w), .ILLEGAL(illegal_w), .PC_OUT(pc_w), .RETIRED(retired_w), .RESULT(result_w));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    logic [11:0] i;
    i = 12'(imm);
    return {i, 5'(rs1), 3'b000, 5'(rd), 7'h13};
  endfunction
  function automatic logic [31:0] rop(input logic [6:0] f7, input logic [2:0] f3, input int rd, input int rs1, input int rs2);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] br(input logic [2:0] f3, input int rs1, input int rs2, input int off);
    logic [12:0] i;
    i = 13'(off);
    return {i[12], i[10:5], 5'(rs2), 5'(rs1), f3, i[4:1], i[11], 7'h63};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1;
    waddr = a;
    wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask
  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic push(input logic [31:0] res, input logic [31:0] r4, input logic [31:0] ret, input logic [31:0] p, input logic ill, input int dur);
    exp_t e;
    e.res = res;
    e.r4 = r4;
    e.ret = ret;
    e.pc = p;
    e.ill = ill;
    e.dur = dur;
    sb.push_back(e);
  endtask
  task automatic wait_halt();
    for (int i = 0; i < 300; i++) begin
      if (halted) return;
      @(negedge clk);
    end
    chk("halt_timeout", 32'd0, 32'd1);
  endtask
  initial forever begin
    @(negedge clk);
    if (busy && !b_prev) fetch_cyc = cyc;
    if (halted && !h_prev) begin
      if (sb.size() == 0) chk("unexpected_halt", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("run%0d result", run), result, e.res);
        chk($sformatf("run%0d x4", run), result4, e.r4);
        chk($sformatf("run%0d retired", run), retired, e.ret);
        chk($sformatf("run%0d pc", run), pc, e.pc);
        chk($sformatf("run%0d illegal", run), {31'b0, illegal}, {31'b0, e.ill});
        chk($sformatf("run%0d halt_cycles", run), 32'(cyc - fetch_cyc), 32'(e.dur));
        run++;
      end
    end
    b_prev = busy;
    h_prev = halted;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset halted", {31'b0, halted}, 32'd0);
    chk("reset illegal", {31'b0, illegal}, 32'd0);
    chk("reset pc", pc, 32'd0);
    chk("reset retired", retired, 32'd0);
    chk("reset result", result, 32'd0);
    rst = 1'b0;
    wr(0, 32'h0000_0003);
    wr(1, addi(2, 0, 7));
    wr(2, rop(7'h00, 3'b000, 3, 3, 2));
    wr(3, ECALL);
    push(32'd12, 32'd0, 32'd3, 32'd12, 1'b0, 15);
    we = 1'b1;
    waddr = 4'd0;
    wdata = addi(3, 0, 5);
    start = 1'b1;
    @(negedge clk);
    we = 1'b0;
    start = 1'b0;
    wait_halt();
    wr(0, addi(1, 0, 1));
    wr(1, addi(0, 0, 9));
    wr(2, rop(7'h00, 3'b000, 3, 0, 0));
    wr(3, rop(7'h20, 3'b000, 3, 3, 1));
    wr(4, rop(7'h00, 3'b010, 4, 3, 0));
    wr(5, ECALL);
    push(32'hFFFF_FFFF, 32'd1, 32'd5, 32'd20, 1'b0, 23);
    go();
    wait_halt();
    wr(0, addi(1, 0, 'hF0));
    wr(1, addi(2, 0, 'h24));
    wr(2, addi(5, 0, -1));
    wr(3, ECALL);
    push(32'hFFFF_FFFF, 32'd1, 32'd3, 32'd12, 1'b0, 15);
    go();
    wait_halt();
    ops = '{rop(7'h00, 3'b111, 3, 1, 2), rop(7'h00, 3'b110, 3, 1, 2), rop(7'h00, 3'b100, 3, 1, 2),
            rop(7'h00, 3'b001, 3, 1, 2), rop(7'h00, 3'b101, 3, 1, 2), rop(7'h00, 3'b101, 3, 5, 2),
            rop(7'h20, 3'b000, 3, 2, 1), rop(7'h00, 3'b010, 3, 1, 2), rop(7'h00, 3'b010, 3, 2, 1),
            rop(7'h00, 3'b000, 3, 1, 2)};
    opx = '{32'h20, 32'hF4, 32'hD4, 32'hF00, 32'hF, 32'h0FFF_FFFF, 32'hFFFF_FF34, 32'h0, 32'h1, 32'h114};
    wr(1, ECALL);
    foreach (ops[k]) begin
      wr(4'(0), ops[k]);
      push(opx[k], 32'd1, 32'd1, 32'd4, 1'b0, 7);
      go();
      wait_halt();
    end
    wr(0, rop(7'h20, 3'b101, 3, 1, 2));
    push(32'h114, 32'd1, 32'd0, 32'd0, 1'b1, 3);
    go();
    wait_halt();
    wr(0, addi(2, 0, 3));
    wr(1, addi(3, 0, 0));
    wr(2, addi(3, 3, 1));
    wr(3, addi(2, 2, -1));
    wr(4, br(3'b001, 2, 0, -8));
    wr(5, ECALL);
    push(32'd3, 32'd1, 32'd11, 32'd20, 1'b0, 47);
    go();
    wait_halt();
    wr(0, br(3'b000, 3, 0, 8));
    wr(1, br(3'b000, 2, 0, 8));
    wr(2, addi(3, 0, 99));
    wr(3, ECALL);
    push(32'd3, 32'd1, 32'd2, 32'd12, 1'b0, 11);
    go();
    wait_halt();
    wr(0, br(3'b000, 0, 0, 6));
    push(32'd3, 32'd1, 32'd0, 32'd0, 1'b1, 3);
    go();
    wait_halt();
    wr(0, addi(3, 0, 7));
    wr(1, addi(3, 3, 1));
    wr(2, 32'h0000_0003);
    push(32'd8, 32'd1, 32'd2, 32'd8, 1'b1, 11);
    go();
    wait_halt();
    wr(0, ECALL);
    push(32'd8, 32'd1, 32'd0, 32'd0, 1'b0, 3);
    go();
    wait_halt();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wr(0, addi(3, 0, 5));
    wr(1, ECALL);
    go();
    @(negedge clk);
    @(negedge clk);
    chk("abort busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort halted", {31'b0, halted}, 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort retired", retired, 32'd0);
    chk("abort pc", pc, 32'd0);
    push(32'd5, 32'd0, 32'd1, 32'd4, 1'b0, 7);
    go();
    we = 1'b1;
    waddr = 4'd0;
    wdata = addi(3, 0, 100);
    repeat (3) @(negedge clk);
    we = 1'b0;
    wait_halt();
    push(32'd5, 32'd0, 32'd1, 32'd4, 1'b0, 7);
    go();
    wait_halt();
    for (int i = 0; i < 4; i++) begin
      we_w = 1'b1;
      waddr_w = 2'(i);
      wdata_w = addi(3, 3, 1);
      @(negedge clk);
    end
    we_w = 1'b0;
    start_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    repeat (16) @(negedge clk);
    chk("wrap pc", pc_w, 32'd0);
    chk("wrap result", result_w, 32'd4);
    chk("wrap retired", retired_w, 32'd4);
    chk("wrap busy", {31'b0, busy_w}, 32'd1);
    repeat (4) @(negedge clk);
    chk("wrap result_next", result_w, 32'd5);
    chk("wrap pc_next", pc_w, 32'd4);
    repeat (2) @(negedge clk);
    chk("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
